// File: rtl/mips_mem_responder.sv
// mips_mem_responder: single-ported word RAM serving the multicycle MIPS core's
// unified memory port. One request at a time over valid/ready, with a fixed
// LATENCY from accept to a one-cycle response pulse.
// Optional build macro MEM_ERR_CHECK_EN: flags misaligned or out-of-range
// accesses, blocks erroneous writes and zeroes erroneous read data.
module mips_mem_responder #(
  parameter int unsigned       WIDTH     = 32,
  parameter int unsigned       DEPTH     = 1024,
  parameter logic [WIDTH-1:0]  BASE_ADDR = WIDTH'(32'h100),
  parameter int unsigned       LATENCY   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic             req_write,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             req_ready,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_err
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam int unsigned CW        = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam int unsigned WAIT_LAST = (LATENCY >= 2) ? LATENCY - 2 : 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             accept;
  logic             enter_resp;

  logic [WIDTH-1:0] offset;
  logic [AW-1:0]    idx;
  logic             err;

  logic [AW-1:0]    addr_q;
  logic             write_q;
  logic [WIDTH-1:0] wdata_q;
  logic             err_q;
  logic [WIDTH-1:0] rd_q;

  logic [AW-1:0]    cur_addr;
  logic             cur_write;
  logic [WIDTH-1:0] cur_wdata;
  logic             cur_err;

  logic [WIDTH-1:0] mem [DEPTH];

  // Address decode: word index relative to BASE_ADDR, plus optional error flag
  always_comb begin
    offset = req_addr - BASE_ADDR;
    idx    = AW'(offset >> 2);
`ifdef MEM_ERR_CHECK_EN
    err    = (req_addr[1:0] != 2'b00) || ((offset >> 2) >= WIDTH'(DEPTH));
`else
    err    = 1'b0;
`endif
  end

  assign accept = req_valid && req_ready;

  // Next-state logic; WAIT spans LATENCY-1 cycles before RESP
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = '0;
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == CW'(WAIT_LAST)) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign enter_resp = (state_d == RESP) && (state_q != RESP);

  // With LATENCY==1 the RAM access happens on the accept edge itself, so the
  // live request is used instead of the latched copy
  always_comb begin
    if (state_q == IDLE) begin
      cur_addr  = idx;
      cur_write = req_write;
      cur_wdata = req_wdata;
      cur_err   = err;
    end else begin
      cur_addr  = addr_q;
      cur_write = write_q;
      cur_wdata = wdata_q;
      cur_err   = err_q;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Latch the request on the accept edge
  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      addr_q  <= idx;
      write_q <= req_write;
      wdata_q <= req_wdata;
      err_q   <= err;
    end
  end

  // RAM commit and read sample on the edge entering RESP; reset cancels it
  always_ff @(posedge clk) begin
    if (reset && enter_resp) begin
      if (cur_write && !cur_err) begin
        mem[cur_addr] <= cur_wdata;
      end
      if (cur_write) begin
        rd_q <= cur_wdata;
      end else if (cur_err) begin
        rd_q <= '0;
      end else begin
        rd_q <= mem[cur_addr];
      end
    end
  end

  // Registered outputs; response data holds between pulses
  always_ff @(posedge clk) begin
    if (!reset) begin
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      req_ready <= (state_d == IDLE);
      rsp_valid <= (state_q == RESP);
      if (state_q == RESP) begin
        rsp_rdata <= rd_q;
        rsp_err   <= err_q;
      end
    end
  end

endmodule

// File: tb/tb_mips_mem_responder.sv
// Testbench for mips_mem_responder: a LATENCY=2 instance and a LATENCY=1
// instance, driven by directed requests; expected responses are queued at
// accept time and checked by a separate monitor process.
module tb_mips_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        v0, w0, rdy0, rv0, re0;
  logic [31:0] a0, d0, rd0;
  logic        v1, w1, rdy1, rv1, re1;
  logic [31:0] a1, d1, rd1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          edge_no;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];

  mips_mem_responder #(
    .WIDTH(32), .DEPTH(1024), .BASE_ADDR(32'h100), .LATENCY(2)
  ) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(v0), .req_write(w0), .req_addr(a0), .req_wdata(d0),
    .req_ready(rdy0), .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(re0)
  );

  mips_mem_responder #(
    .WIDTH(32), .DEPTH(1024), .BASE_ADDR(32'h100), .LATENCY(1)
  ) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(v1), .req_write(w1), .req_addr(a1), .req_wdata(d1),
    .req_ready(rdy1), .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(re1)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at a negedge; waits for ready, queues the expected response and
  // returns at the negedge after the accept edge with req_valid still high.
  task automatic issue(input int sel, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] er, input logic ee,
                       input bit expect_rsp, output int waited);
    int lat;
    lat    = (sel == 0) ? 2 : 1;
    waited = 0;
    if (sel == 0) begin
      v0 = 1'b1; w0 = w; a0 = a; d0 = d;
    end else begin
      v1 = 1'b1; w1 = w; a1 = a; d1 = d;
    end
    while (((sel == 0) ? rdy0 : rdy1) == 1'b0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (((sel == 0) ? rdy0 : rdy1) == 1'b0) begin
      check("accept_timeout", 32'(0), 32'(1));
    end else if (expect_rsp) begin
      if (sel == 0) sb0.push_back('{er, ee, cyc + 1 + lat});
      else          sb1.push_back('{er, ee, cyc + 1 + lat});
    end
    @(negedge clk);
  endtask

  task automatic drop();
    v0 = 1'b0;
    v1 = 1'b0;
  endtask

  // Pops the scoreboards whenever a response pulse is seen
  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (rv0) begin
          if (sb0.size() == 0) begin
            check("rsp0_unexpected", 32'(rv0), 32'(0));
          end else begin
            e = sb0.pop_front();
            check("rsp0_rdata", rd0, e.rdata);
            check("rsp0_err", 32'(re0), 32'(e.err));
            check("rsp0_time", 32'(cyc), 32'(e.edge_no));
          end
        end
        if (rv1) begin
          if (sb1.size() == 0) begin
            check("rsp1_unexpected", 32'(rv1), 32'(0));
          end else begin
            e = sb1.pop_front();
            check("rsp1_rdata", rd1, e.rdata);
            check("rsp1_err", 32'(re1), 32'(e.err));
            check("rsp1_time", 32'(cyc), 32'(e.edge_no));
          end
        end
      end
    end
  endtask

  initial begin
    int wt;
    reset = 1'b0;
    v0 = 1'b0; w0 = 1'b0; a0 = '0; d0 = '0;
    v1 = 1'b0; w1 = 1'b0; a1 = '0; d1 = '0;
    fork
      monitor_loop();
    join_none

    // Reset held three cycles
    repeat (3) begin
      @(negedge clk);
      check("reset_ready", 32'(rdy0), 32'(0));
      check("reset_valid", 32'(rv0), 32'(0));
      check("reset_rdata", rd0, 32'h0);
      check("reset_err", 32'(re0), 32'(0));
    end
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_release", 32'(rdy0), 32'(1));
    check("ready1_after_release", 32'(rdy1), 32'(1));

    // Write then read word 0
    issue(0, 1'b1, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b1, wt); drop();
    issue(0, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, wt); drop();

    // Fill three words, then read them back-to-back with req_valid held
    issue(0, 1'b1, 32'h104, 32'h11111111, 32'h11111111, 1'b0, 1'b1, wt); drop();
    issue(0, 1'b1, 32'h108, 32'h22222222, 32'h22222222, 1'b0, 1'b1, wt); drop();
    issue(0, 1'b1, 32'h10C, 32'h33333333, 32'h33333333, 1'b0, 1'b1, wt); drop();
    issue(0, 1'b0, 32'h104, 32'h0, 32'h11111111, 1'b0, 1'b1, wt);
    issue(0, 1'b0, 32'h108, 32'h0, 32'h22222222, 1'b0, 1'b1, wt);
    check("b2b_gap1", 32'(wt), 32'(2));
    issue(0, 1'b0, 32'h10C, 32'h0, 32'h33333333, 1'b0, 1'b1, wt);
    check("b2b_gap2", 32'(wt), 32'(2));
    drop();

    // Reset one cycle after accepting a write: no response, no RAM update
    issue(0, 1'b1, 32'h104, 32'h00000001, 32'h0, 1'b0, 1'b0, wt); drop();
    reset = 1'b0;
    @(negedge clk);
    check("abort_valid", 32'(rv0), 32'(0));
    @(negedge clk);
    check("abort_valid2", 32'(rv0), 32'(0));
    reset = 1'b1;
    @(negedge clk);
    issue(0, 1'b0, 32'h104, 32'h0, 32'h11111111, 1'b0, 1'b1, wt); drop();

`ifdef MEM_ERR_CHECK_EN
    issue(0, 1'b0, 32'h102, 32'h0, 32'h0, 1'b1, 1'b1, wt); drop();
    issue(0, 1'b1, 32'h1100, 32'h55, 32'h55, 1'b1, 1'b1, wt); drop();
    issue(0, 1'b0, 32'h0FC, 32'h0, 32'h0, 1'b1, 1'b1, wt); drop();
    issue(0, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, wt); drop();
`else
    issue(0, 1'b0, 32'h102, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, wt); drop();
    issue(0, 1'b1, 32'h1100, 32'h55, 32'h55, 1'b0, 1'b1, wt); drop();
    issue(0, 1'b0, 32'h100, 32'h0, 32'h55, 1'b0, 1'b1, wt); drop();
`endif

    // LATENCY=1 instance: response one cycle after accept, back-to-back read
    issue(1, 1'b1, 32'h200, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 1'b1, wt);
    issue(1, 1'b0, 32'h200, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b1, wt);
    check("lat1_gap", 32'(wt), 32'(1));
    drop();
    issue(1, 1'b0, 32'h200, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b1, wt); drop();

    repeat (6) @(negedge clk);
    check("sb0_drain", 32'(sb0.size()), 32'(0));
    check("sb1_drain", 32'(sb1.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
